// File: rtl/fuzzy_mmio_pkg.sv
// fuzzy_mmio_pkg: register map, control/irq bit positions and default fuzzy parameter tables
package fuzzy_mmio_pkg;

    localparam int A_STATUS   = 'h00;
    localparam int A_CTRL     = 'h01;
    localparam int A_T        = 'h02;
    localparam int A_DT       = 'h03;
    localparam int A_GOUT     = 'h04;
    localparam int A_IRQ_STAT = 'h05;
    localparam int A_IRQ_EN   = 'h06;
    localparam int MF_BASE    = 'h10;
    localparam int G_BASE     = 'h40;
    localparam int EST_BASE   = 'h60;

    localparam int C_START    = 0;
    localparam int C_REG_MODE = 1;
    localparam int C_DT_MODE  = 2;
    localparam int C_INIT     = 3;
    localparam int C_COMMIT   = 4;

    localparam int I_DONE     = 0;
    localparam int I_ERR_ADDR = 1;
    localparam int I_ERR_BUSY = 2;

    localparam logic [7:0] MF_DEF [24] = '{
        8'h80, 8'h80, 8'hF0, 8'hFC,
        8'hF0, 8'h00, 8'h00, 8'h10,
        8'h04, 8'h10, 8'h7F, 8'h7F,
        8'h80, 8'hC0, 8'hF8, 8'h00,
        8'hF8, 8'h00, 8'h00, 8'h08,
        8'h00, 8'h08, 8'h40, 8'h7F
    };

    localparam logic [7:0] G_DEF [9] = '{
        8'd100, 8'd50, 8'd30, 8'd50, 8'd50, 8'd50, 8'd80, 8'd50, 8'd0
    };

    localparam logic [7:0] EST_DEF [3] = '{8'd32, 8'd3, 8'd64};

    typedef enum logic [1:0] {IDLE, PEND, COPY} bank_state_e;

endpackage

// File: rtl/mmio_regfile_if.sv
// mmio_regfile_if: single-cycle strobe register bus with registered read return
interface mmio_regfile_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          cs;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (output cs, wr, rd, addr, wdata, input rdata, rvalid);
    modport slave  (input cs, wr, rd, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/mmio_regfile_param_bank.sv
// param_bank: shadow/active fuzzy parameter banks with a commit FSM that defers copies while busy
module param_bank
    import fuzzy_mmio_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int N_IN   = 2,
    parameter int N_MF   = 3,
    parameter int N_RULE = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    input  logic                 commit_req,
    input  logic                 busy,
    output logic                 hit,
    output logic [DW-1:0]        rd_data,
    output logic                 commit_pend,
    output logic signed [DW-1:0] mf_p [N_IN*N_MF*4],
    output logic [DW-1:0]        g [N_RULE],
    output logic [DW-1:0]        alpha,
    output logic [DW-1:0]        k_dt,
    output logic signed [DW-1:0] d_max
);
    localparam int NMF = N_IN * N_MF * 4;
    localparam int NP  = NMF + N_RULE + 3;
    localparam int IW  = $clog2(NP);
    localparam bit USE_DEF = (N_IN == 2) && (N_MF == 3) && (DW == 8);

    bank_state_e   state_q, state_d;
    logic [DW-1:0] sh_q [NP];
    logic [DW-1:0] sh_d [NP];
    logic [DW-1:0] act_q [NP];
    logic [DW-1:0] act_d [NP];
    logic [DW-1:0] rst_v [NP];
    logic [IW-1:0] idx;
    logic          go;
    logic          copy;
    int            a;

    for (genvar i = 0; i < NP; i++) begin : g_rv
        if (!USE_DEF) begin : g_zero
            assign rst_v[i] = '0;
        end else if (i < 24) begin : g_mf
            assign rst_v[i] = DW'(MF_DEF[i]);
        end else if (i < 33) begin : g_g
            assign rst_v[i] = DW'(G_DEF[i-24]);
        end else begin : g_est
            assign rst_v[i] = DW'(EST_DEF[i-33]);
        end
    end

    for (genvar i = 0; i < NMF; i++) begin : g_mfo
        assign mf_p[i] = act_q[i];
    end
    for (genvar i = 0; i < N_RULE; i++) begin : g_go
        assign g[i] = act_q[NMF+i];
    end
    assign alpha       = act_q[NMF+N_RULE];
    assign k_dt        = act_q[NMF+N_RULE+1];
    assign d_max       = act_q[NMF+N_RULE+2];
    assign commit_pend = state_q == PEND;

    // decode bus address into a flat bank index; reads always see the shadow bank
    always_comb begin
        a   = int'(addr);
        hit = 1'b1;
        idx = '0;
        if (a >= MF_BASE && a < MF_BASE + NMF) idx = IW'(a - MF_BASE);
        else if (a >= G_BASE && a < G_BASE + N_RULE) idx = IW'(a - G_BASE + NMF);
        else if (a >= EST_BASE && a < EST_BASE + 3) idx = IW'(a - EST_BASE + NMF + N_RULE);
        else hit = 1'b0;
        rd_data = sh_q[idx];
    end

    // commit FSM plus bank next-state: copy takes the pre-write shadow, repeat commits while pending are absorbed
    always_comb begin
        go      = commit_req | (state_q == PEND);
        copy    = go & ~busy;
        state_d = copy ? COPY : go ? PEND : IDLE;
        sh_d    = sh_q;
        act_d   = act_q;
        if (wr_req && hit) sh_d[idx] = wdata;
        if (copy) act_d = sh_q;
    end

    // bank and FSM registers, reloaded with defaults on reset (which also drops a pending commit)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= rst_v;
            act_q   <= rst_v;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
        end
    end
endmodule

// File: rtl/mmio_regfile.sv
// mmio_regfile: memory-mapped control/status registers and double-buffered fuzzy controller parameters
module mmio_regfile
    import fuzzy_mmio_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int N_IN   = 2,
    parameter int N_MF   = 3,
    parameter int N_RULE = N_MF ** N_IN
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_regfile_if.slave        bus,
    output logic                 start_pulse,
    output logic                 init_pulse,
    output logic                 reg_mode,
    output logic                 dt_mode,
    output logic                 irq,
    output logic signed [DW-1:0] T_reg,
    output logic signed [DW-1:0] dT_reg,
    output logic signed [DW-1:0] mf_p [N_IN*N_MF*4],
    output logic [DW-1:0]        g [N_RULE],
    output logic [DW-1:0]        alpha,
    output logic [DW-1:0]        k_dt,
    output logic signed [DW-1:0] d_max,
    input  logic                 busy,
    input  logic                 valid,
    input  logic signed [DW-1:0] dT_live,
    input  logic [DW-1:0]        G_out
);
    if (MF_BASE + 4 * N_IN * N_MF > G_BASE || N_RULE > 32 || (AW == 8 && DW > 8)) begin : g_bad_cfg
        $error("mmio_regfile: parameter set does not fit the register map");
    end

    logic          start_pulse_q, start_pulse_d, init_pulse_q, init_pulse_d;
    logic          reg_mode_q, reg_mode_d, dt_mode_q, dt_mode_d;
    logic          irq_q, irq_d, valid_q, rvalid_q, rvalid_d;
    logic [DW-1:0] t_q, t_d, dt_q, dt_d, rdata_q, rdata_d, rmux, bank_rd;
    logic [2:0]    irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, irq_set, w1c;
    logic          wr_acc, rd_acc, wctrl, commit_req, bank_hit, commit_pend;
    logic          sel_status, sel_ctrl, sel_t, sel_dt, sel_gout, sel_irqs, sel_irqen, mapped, ro;
    int            a;

    param_bank #(
        .DW(DW), .AW(AW), .N_IN(N_IN), .N_MF(N_MF), .N_RULE(N_RULE)
    ) u_bank (
        .clk(clk), .rst(rst), .wr_req(wr_acc), .addr(bus.addr), .wdata(bus.wdata),
        .commit_req(commit_req), .busy(busy), .hit(bank_hit), .rd_data(bank_rd),
        .commit_pend(commit_pend), .mf_p(mf_p), .g(g), .alpha(alpha), .k_dt(k_dt), .d_max(d_max)
    );

    assign start_pulse = start_pulse_q;
    assign init_pulse  = init_pulse_q;
    assign reg_mode    = reg_mode_q;
    assign dt_mode     = dt_mode_q;
    assign irq         = irq_q;
    assign T_reg       = t_q;
    assign dT_reg      = dt_q;
    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;

    // bus decode, register updates, sticky interrupt sources and the read-return mux
    always_comb begin
        a             = int'(bus.addr);
        wr_acc        = bus.cs & bus.wr;
        rd_acc        = bus.cs & bus.rd & ~bus.wr;
        sel_status    = a == A_STATUS;
        sel_ctrl      = a == A_CTRL;
        sel_t         = a == A_T;
        sel_dt        = a == A_DT;
        sel_gout      = a == A_GOUT;
        sel_irqs      = a == A_IRQ_STAT;
        sel_irqen     = a == A_IRQ_EN;
        mapped        = (a <= A_IRQ_EN) | bank_hit;
        ro            = sel_status | sel_gout;
        wctrl         = wr_acc & sel_ctrl;
        start_pulse_d = wctrl & bus.wdata[C_START] & ~busy;
        init_pulse_d  = wctrl & bus.wdata[C_INIT];
        commit_req    = wctrl & bus.wdata[C_COMMIT];
        reg_mode_d    = wctrl ? bus.wdata[C_REG_MODE] : reg_mode_q;
        dt_mode_d     = wctrl ? bus.wdata[C_DT_MODE] : dt_mode_q;
        t_d           = (wr_acc & sel_t) ? bus.wdata : t_q;
        dt_d          = (wr_acc & sel_dt & ~dt_mode_q) ? bus.wdata : dt_q;
        irq_set             = '0;
        irq_set[I_DONE]     = valid & ~valid_q;
        irq_set[I_ERR_ADDR] = (wr_acc & (~mapped | ro)) | (rd_acc & ~mapped);
        irq_set[I_ERR_BUSY] = wctrl & bus.wdata[C_START] & busy;
        w1c           = (wr_acc & sel_irqs) ? bus.wdata[2:0] : 3'b000;
        irq_stat_d    = (irq_stat_q & ~w1c) | irq_set;
        irq_en_d      = (wr_acc & sel_irqen) ? bus.wdata[2:0] : irq_en_q;
        irq_d         = |(irq_stat_d & irq_en_d);
        rmux = sel_status ? DW'({commit_pend, valid, busy})
             : sel_ctrl   ? DW'({dt_mode_q, reg_mode_q, 1'b0})
             : sel_t      ? t_q
             : sel_dt     ? (dt_mode_q ? dT_live : dt_q)
             : sel_gout   ? G_out
             : sel_irqs   ? DW'(irq_stat_q)
             : sel_irqen  ? DW'(irq_en_q)
             : bank_hit   ? bank_rd
             : '0;
        rvalid_d      = rd_acc;
        rdata_d       = rd_acc ? rmux : rdata_q;
    end

    // control/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            start_pulse_q <= 1'b0;
            init_pulse_q  <= 1'b0;
            reg_mode_q    <= 1'b0;
            dt_mode_q     <= 1'b1;
            t_q           <= '0;
            dt_q          <= '0;
            irq_stat_q    <= '0;
            irq_en_q      <= '0;
            irq_q         <= 1'b0;
            valid_q       <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            start_pulse_q <= start_pulse_d;
            init_pulse_q  <= init_pulse_d;
            reg_mode_q    <= reg_mode_d;
            dt_mode_q     <= dt_mode_d;
            t_q           <= t_d;
            dt_q          <= dt_d;
            irq_stat_q    <= irq_stat_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
            valid_q       <= valid;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end
endmodule
